// File: rtl/vram_arbiter.sv
// Purpose : slot scheduler for the VDP's single-port VRAM, shared by tile fetch and CPU.
// Latency : issue on a slot_en edge, capture on the next slot_en edge (read ack one slot after grant).
// Backpres: posted writes are buffered in a WFIFO_DEPTH FIFO, and a push while full is dropped and sets a sticky flag.
//           CPU reads are req/ack and are granted only in a CPU slot with the FIFO empty.
//
// Ports:
//   i_clk, i_rst_n         clock, asynchronous active-low reset
//   i_slot_en/line_start   slot advance strobe / restart at slot 0
//   i_blank                every slot belongs to the CPU while high
//   i_disp_addr            display fetch address for the slot being entered
//   o_disp_slot            current slot index
//   o_disp_rdata/_rvalid   display read data and its 1-clk update pulse
//   i_cpu_rd_req/_addr     CPU read request, held until o_cpu_rd_ack
//   o_cpu_rd_ack/o_cpu_rdata  1-clk ack pulse and held read data
//   i_cpu_wr_req/_addr/_data  1-clk posted-write push
//   o_cpu_wr_full/_overflow   FIFO full and sticky dropped-push flag
//   o_mem_addr/_we/_wdata  registered VRAM controls, held for the whole slot
//   i_mem_rdata            VRAM read data, valid one clk after the address is sampled
module vram_arbiter #(
  parameter int ADDR_WIDTH  = 15,
  parameter int DATA_WIDTH  = 8,
  parameter int SLOTS       = 8,
  parameter int DISP_SLOTS  = 6,
  parameter int WFIFO_DEPTH = 4,
  localparam int SLOT_W     = $clog2(SLOTS),
  localparam int PTR_W      = $clog2(WFIFO_DEPTH),
  localparam int CNT_W      = PTR_W + 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_slot_en,
  input  logic                  i_line_start,
  input  logic                  i_blank,
  input  logic [ADDR_WIDTH-1:0] i_disp_addr,
  output logic [SLOT_W-1:0]     o_disp_slot,
  output logic [DATA_WIDTH-1:0] o_disp_rdata,
  output logic                  o_disp_rvalid,
  input  logic                  i_cpu_rd_req,
  input  logic [ADDR_WIDTH-1:0] i_cpu_rd_addr,
  output logic                  o_cpu_rd_ack,
  output logic [DATA_WIDTH-1:0] o_cpu_rdata,
  input  logic                  i_cpu_wr_req,
  input  logic [ADDR_WIDTH-1:0] i_cpu_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_cpu_wr_data,
  output logic                  o_cpu_wr_full,
  output logic                  o_cpu_wr_overflow,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_we,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

  logic [SLOT_W-1:0]     r_slot;
  logic                  r_disp_pend;    // slot just issued was a display read
  logic                  r_rd_inflight;  // slot just issued was the CPU read

  logic [ADDR_WIDTH-1:0] r_fifo_addr [WFIFO_DEPTH];
  logic [DATA_WIDTH-1:0] r_fifo_data [WFIFO_DEPTH];
  logic [PTR_W-1:0]      r_wptr;
  logic [PTR_W-1:0]      r_rptr;
  logic [CNT_W-1:0]      r_count;

  logic [SLOT_W-1:0]     w_next_slot;
  logic                  w_disp_owner;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_grant;

  // SLOTS is a power of two, so the natural wrap of the counter gives mod SLOTS.
  assign w_next_slot  = i_line_start ? '0 : r_slot + 1'b1;
  assign w_disp_owner = ({1'b0, w_next_slot} < (SLOT_W+1)'(DISP_SLOTS)) && !i_blank;

  // Full/empty come from the count before this edge: a push while full is dropped even if
  // a pop happens on the same edge, and a push into an empty FIFO cannot be popped at once.
  assign w_full  = (r_count == CNT_W'(WFIFO_DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = i_cpu_wr_req && !w_full;
  assign w_pop   = i_slot_en && !w_disp_owner && !w_empty;
  // Posted writes always win the CPU slot so a read sees every earlier write.
  assign w_grant = i_slot_en && !w_disp_owner && w_empty && i_cpu_rd_req && !r_rd_inflight;

  assign o_disp_slot   = r_slot;
  assign o_cpu_wr_full = w_full;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_slot        <= '0;
      r_disp_pend   <= 1'b0;
      r_rd_inflight <= 1'b0;
      o_mem_addr    <= '0;
      o_mem_we      <= 1'b0;
      o_mem_wdata   <= '0;
      o_disp_rdata  <= '0;
      o_disp_rvalid <= 1'b0;
      o_cpu_rdata   <= '0;
      o_cpu_rd_ack  <= 1'b0;
    end else begin
      o_disp_rvalid <= 1'b0;
      o_cpu_rd_ack  <= 1'b0;
      if (i_slot_en) begin
        r_slot <= w_next_slot;
        // Capture the read issued in the slot that is ending.
        if (r_disp_pend) begin
          o_disp_rdata  <= i_mem_rdata;
          o_disp_rvalid <= 1'b1;
        end
        if (r_rd_inflight) begin
          o_cpu_rdata  <= i_mem_rdata;
          o_cpu_rd_ack <= 1'b1;
        end
        // Issue for the slot being entered.
        r_disp_pend   <= w_disp_owner;
        r_rd_inflight <= w_grant;
        o_mem_we      <= w_pop;
        if (w_disp_owner) begin
          o_mem_addr <= i_disp_addr;
        end else if (w_pop) begin
          o_mem_addr  <= r_fifo_addr[r_rptr];
          o_mem_wdata <= r_fifo_data[r_rptr];
        end else if (w_grant) begin
          o_mem_addr <= i_cpu_rd_addr;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr            <= '0;
      r_rptr            <= '0;
      r_count           <= '0;
      o_cpu_wr_overflow <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (i_cpu_wr_req && w_full) o_cpu_wr_overflow <= 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read behind the write pointer.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fifo_addr[r_wptr] <= i_cpu_wr_addr;
      r_fifo_data[r_wptr] <= i_cpu_wr_data;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
module tb_vram_arbiter;
  localparam int AW = 15, DW = 8, SLOTS = 8, DISP = 6, DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, slot_en, line_start, blank;
  logic [AW-1:0] disp_addr, cpu_rd_addr, cpu_wr_addr, mem_addr;
  logic [2:0]    disp_slot;
  logic [DW-1:0] disp_rdata, cpu_rdata, cpu_wr_data, mem_wdata, mem_rdata;
  logic          disp_rvalid, cpu_rd_req, cpu_rd_ack, cpu_wr_req, cpu_wr_full, cpu_wr_overflow, mem_we;

  vram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SLOTS(SLOTS), .DISP_SLOTS(DISP), .WFIFO_DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_slot_en(slot_en), .i_line_start(line_start), .i_blank(blank),
    .i_disp_addr(disp_addr), .o_disp_slot(disp_slot), .o_disp_rdata(disp_rdata), .o_disp_rvalid(disp_rvalid),
    .i_cpu_rd_req(cpu_rd_req), .i_cpu_rd_addr(cpu_rd_addr), .o_cpu_rd_ack(cpu_rd_ack), .o_cpu_rdata(cpu_rdata),
    .i_cpu_wr_req(cpu_wr_req), .i_cpu_wr_addr(cpu_wr_addr), .i_cpu_wr_data(cpu_wr_data),
    .o_cpu_wr_full(cpu_wr_full), .o_cpu_wr_overflow(cpu_wr_overflow),
    .o_mem_addr(mem_addr), .o_mem_we(mem_we), .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata));

  function automatic logic [DW-1:0] init_val(input int a);
    return DW'((a * 37 + 11) ^ (a >> 7));
  endfunction

  // Synchronous single-port VRAM (read-first).
  logic [DW-1:0] vram [0:32767];
  always @(posedge clk) begin
    if (mem_we) vram[mem_addr] <= mem_wdata;
    mem_rdata <= vram[mem_addr];
  end

  // ---------------- reference model ----------------
  int            m_slot;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_drdata, m_crdata, m_pend_data;
  logic          m_we, m_dval, m_ack, m_ovf;
  int            m_pend;                 // 0 nothing to capture, 1 display read, 2 CPU read
  logic [AW+DW-1:0] m_q[$];
  logic [DW-1:0] m_mem [0:32767];

  task automatic model_reset();
    m_slot = 0; m_addr = '0; m_we = 0; m_wdata = '0; m_drdata = '0; m_crdata = '0;
    m_dval = 0; m_ack = 0; m_ovf = 0; m_pend = 0; m_q.delete();
  endtask

  task automatic model_edge();
    bit was_full, was_empty;
    int prev;
    was_full  = (m_q.size() == DEPTH);
    was_empty = (m_q.size() == 0);
    m_dval = 0; m_ack = 0;
    if (slot_en) begin
      prev = m_pend;
      if (prev == 1) begin m_drdata = m_pend_data; m_dval = 1; end
      if (prev == 2) begin m_crdata = m_pend_data; m_ack = 1; end
      m_slot = line_start ? 0 : (m_slot + 1) % SLOTS;
      if (m_slot < DISP && !blank) begin
        m_addr = disp_addr; m_we = 0; m_pend = 1; m_pend_data = m_mem[disp_addr];
      end else if (!was_empty) begin
        {m_addr, m_wdata} = m_q.pop_front();
        m_we = 1; m_mem[m_addr] = m_wdata; m_pend = 0;
      end else if (cpu_rd_req && prev != 2) begin
        m_addr = cpu_rd_addr; m_we = 0; m_pend = 2; m_pend_data = m_mem[cpu_rd_addr];
      end else begin
        m_we = 0; m_pend = 0;
      end
    end
    if (cpu_wr_req) begin
      if (was_full) m_ovf = 1;
      else m_q.push_back({cpu_wr_addr, cpu_wr_data});
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_edge();
    end
  end

  // ---------------- checking ----------------
  int n_vec = 0, n_err = 0;
  bit chk_en = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("slot", 32'(disp_slot), 32'(m_slot));
      check("mem_addr", 32'(mem_addr), 32'(m_addr));
      check("mem_we", 32'(mem_we), 32'(m_we));
      check("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
      check("disp_rdata", 32'(disp_rdata), 32'(m_drdata));
      check("disp_rvalid", 32'(disp_rvalid), 32'(m_dval));
      check("cpu_rdata", 32'(cpu_rdata), 32'(m_crdata));
      check("cpu_rd_ack", 32'(cpu_rd_ack), 32'(m_ack));
      check("wr_full", 32'(cpu_wr_full), 32'(m_q.size() == DEPTH));
      check("wr_overflow", 32'(cpu_wr_overflow), 32'(m_ovf));
    end
  end

  // ---------------- stimulus helpers ----------------
  int wl_slot[$], wl_addr[$], wl_data[$];
  int n_dval;

  task automatic cyc();
    @(negedge clk);
  endtask

  // One idle clk, then one slot_en clk; returns just after the slot_en edge.
  task automatic slot_step(input bit ls, input bit wr_edge, input bit rnd_disp);
    int nxt;
    cyc();
    nxt = ls ? 0 : (m_slot + 1) % SLOTS;
    line_start = ls;
    slot_en    = 1'b1;
    disp_addr  = rnd_disp ? AW'(32'h200 + $urandom_range(0, 15)) : AW'(16 + nxt);
    cpu_wr_req = wr_edge;
    cyc();
    slot_en = 1'b0; line_start = 1'b0; cpu_wr_req = 1'b0;
    if (mem_we) begin
      wl_slot.push_back(int'(disp_slot)); wl_addr.push_back(int'(mem_addr)); wl_data.push_back(int'(mem_wdata));
    end
    if (disp_rvalid) n_dval++;
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
    cpu_wr_addr = a; cpu_wr_data = d; cpu_wr_req = 1'b1;
    cyc();
    cpu_wr_req = 1'b0;
  endtask

  task automatic clear_log();
    wl_slot.delete(); wl_addr.delete(); wl_data.delete(); n_dval = 0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit got;
    int ack_slot;
    logic [DW-1:0] ack_data;

    for (int a = 0; a < 32768; a++) begin
      vram[a]  = init_val(a);
      m_mem[a] = init_val(a);
    end
    rst_n = 0; slot_en = 0; line_start = 0; blank = 0; disp_addr = '0;
    cpu_rd_req = 0; cpu_rd_addr = '0; cpu_wr_req = 0; cpu_wr_addr = '0; cpu_wr_data = '0;
    repeat (3) cyc();
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_slot", 32'(disp_slot), 0);
    check("rst_full", 32'(cpu_wr_full), 0);
    check("rst_ovf", 32'(cpu_wr_overflow), 0);
    rst_n = 1;
    chk_en = 1;

    // 1: display slots fetch 0x0010+slot
    clear_log();
    for (int i = 0; i < 8; i++) begin
      slot_step(i == 0, 0, 0);
      if (i < 6) begin
        check("t1_addr", 32'(mem_addr), 32'h10 + i);
        check("t1_we", 32'(mem_we), 0);
      end
      if (i == 1) check("t1_first_data", 32'(disp_rdata), 32'(init_val(32'h10)));
    end
    check("t1_rvalid_count", n_dval, 6);

    // 2: three posted writes drain in CPU slots 6, 7, then next group's 6
    slot_step(0, 0, 0);
    check("t2_at_slot0", 32'(disp_slot), 0);
    clear_log();
    push(15'h0100, 8'hAA); push(15'h0101, 8'hBB); push(15'h0102, 8'hCC);
    repeat (16) slot_step(0, 0, 0);
    check("t2_nwrites", wl_addr.size(), 3);
    if (wl_addr.size() == 3) begin
      check("t2_w0_slot", wl_slot[0], 6); check("t2_w0_addr", wl_addr[0], 32'h100); check("t2_w0_data", wl_data[0], 32'hAA);
      check("t2_w1_slot", wl_slot[1], 7); check("t2_w1_addr", wl_addr[1], 32'h101); check("t2_w1_data", wl_data[1], 32'hBB);
      check("t2_w2_slot", wl_slot[2], 6); check("t2_w2_addr", wl_addr[2], 32'h102); check("t2_w2_data", wl_data[2], 32'hCC);
    end

    // 3: five pushes without slot_en -> full after 4, 5th dropped, overflow sticky
    clear_log();
    for (int i = 0; i < 5; i++) begin
      push(AW'(32'h110 + i), DW'(32'h10 + i));
      if (i == 3) begin check("t3_full4", 32'(cpu_wr_full), 1); check("t3_ovf4", 32'(cpu_wr_overflow), 0); end
      if (i == 4) check("t3_ovf5", 32'(cpu_wr_overflow), 1);
    end
    repeat (16) slot_step(0, 0, 0);
    check("t3_nwrites", wl_addr.size(), 4);
    for (int i = 0; i < 4 && i < wl_addr.size(); i++) begin
      check("t3_addr", wl_addr[i], 32'h110 + i);
      check("t3_data", wl_data[i], 32'h10 + i);
    end
    check("t3_ovf_sticky", 32'(cpu_wr_overflow), 1);
    check("t3_not_full", 32'(cpu_wr_full), 0);

    // 4: read after posted write to the same address returns the new data
    clear_log();
    push(15'h0200, 8'h55);
    cpu_rd_addr = 15'h0200; cpu_rd_req = 1;
    got = 0; ack_slot = -1; ack_data = '0;
    for (int k = 0; k < 24 && !got; k++) begin
      slot_step(0, 0, 0);
      if (cpu_rd_ack) begin got = 1; ack_slot = int'(disp_slot); ack_data = cpu_rdata; end
    end
    cpu_rd_req = 0;
    check("t4_ack_seen", 32'(got), 1);
    check("t4_rdata", 32'(ack_data), 32'h55);
    check("t4_ack_slot", ack_slot, 0);
    check("t4_nwrites", wl_addr.size(), 1);
    if (wl_slot.size() == 1) check("t4_write_slot", wl_slot[0], 6);

    // 5: blanking makes slot 0 a CPU slot
    while (m_slot != 7) slot_step(0, 0, 0);
    blank = 1; cpu_rd_addr = 15'h1234; cpu_rd_req = 1; n_dval = 0;
    slot_step(0, 0, 0);
    check("t5_grant_slot", 32'(disp_slot), 0);
    check("t5_grant_addr", 32'(mem_addr), 32'h1234);
    check("t5_grant_we", 32'(mem_we), 0);
    slot_step(0, 0, 0);
    check("t5_ack", 32'(cpu_rd_ack), 1);
    check("t5_ack_slot", 32'(disp_slot), 1);
    check("t5_rdata", 32'(cpu_rdata), 32'(init_val(32'h1234)));
    cpu_rd_req = 0;
    repeat (6) slot_step(0, 0, 0);
    check("t5_no_rvalid", n_dval, 0);

    // 6: reset with a read in flight and two queued writes
    cpu_rd_addr = 15'h0300; cpu_rd_req = 1;
    slot_step(0, 0, 0);
    check("t6_grant_addr", 32'(mem_addr), 32'h300);
    push(15'h0301, 8'h11); push(15'h0302, 8'h22);
    #2 rst_n = 0;
    #1;
    check("t6_rst_addr", 32'(mem_addr), 0);
    check("t6_rst_slot", 32'(disp_slot), 0);
    check("t6_rst_rdata", 32'(cpu_rdata), 0);
    check("t6_rst_drdata", 32'(disp_rdata), 0);
    check("t6_rst_full", 32'(cpu_wr_full), 0);
    check("t6_rst_ovf", 32'(cpu_wr_overflow), 0);
    cyc(); cyc();
    rst_n = 1;
    clear_log();
    slot_step(0, 0, 0);
    check("t6_regrant_addr", 32'(mem_addr), 32'h300);
    check("t6_no_early_ack", 32'(cpu_rd_ack), 0);
    slot_step(0, 0, 0);
    check("t6_ack", 32'(cpu_rd_ack), 1);
    check("t6_rdata", 32'(cpu_rdata), 32'(init_val(32'h300)));
    cpu_rd_req = 0;
    repeat (8) slot_step(0, 0, 0);
    check("t6_no_stale_writes", wl_addr.size(), 0);
    blank = 0;

    // Random traffic against the model
    for (int n = 0; n < 2500; n++) begin
      bit ls, we_edge;
      if ($urandom_range(0, 19) == 0) blank = ~blank;
      ls = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 9) == 0) push(AW'(32'h200 + $urandom_range(0, 15)), DW'($urandom));
      we_edge = ($urandom_range(0, 19) == 0);
      if (we_edge) begin
        cpu_wr_addr = AW'(32'h200 + $urandom_range(0, 15)); cpu_wr_data = DW'($urandom);
      end
      if (!cpu_rd_req && $urandom_range(0, 4) == 0) begin
        cpu_rd_req = 1; cpu_rd_addr = AW'(32'h200 + $urandom_range(0, 15));
      end
      slot_step(ls, we_edge, 1);
      if (m_ack) cpu_rd_req = 0;
    end

    cyc();
    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
